rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 25 ++
 rtl/rob.sv | 148 ++++++++++++++
 tb/tb_rob.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: entry-count width, instruction type encodings
// and the id type used for head/tail/search ports.
`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif

package rob_pkg;

    localparam int ROB_W    = `ROB_WIDTH;
    localparam int ROB_SIZE = 1 << ROB_W;

    typedef enum logic [1:0] {
        ROB_REG = 2'd0,
        ROB_BR  = 2'd1,
        ROB_ST  = 2'd2
    } rob_type_e;

    typedef logic [ROB_W-1:0] rob_id_t;

    // ROB_SIZE is a power of two, so the pointer wraps by plain overflow.
    function automatic rob_id_t rob_next(input rob_id_t p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/rob.sv
// In-order reorder buffer: allocates entries at issue, collects writebacks out of
// order, retires one ready entry per cycle from the head and flushes on a mispredicted branch.
module rob
    import rob_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,

    input  logic                  issue_valid,
    input  logic [1:0]            issue_type,
    input  logic [4:0]            issue_rd,
    output logic [`ROB_WIDTH-1:0] issue_rob_id,
    output logic                  rob_full,

    input  logic                  wb_valid,
    input  logic [`ROB_WIDTH-1:0] wb_rob_id,
    input  logic [31:0]           wb_val,
    input  logic                  wb_mispredict,
    input  logic [31:0]           wb_target,

    output logic                  commit_ready,
    output logic [4:0]            commit_reg_id,
    output logic [31:0]           commit_val,
    output logic [`ROB_WIDTH-1:0] commit_rob_id,
    output logic                  commit_store,

    input  logic [`ROB_WIDTH-1:0] search_rob_id_1,
    output logic                  search_ready_1,
    output logic [31:0]           search_val_1,
    input  logic [`ROB_WIDTH-1:0] search_rob_id_2,
    output logic                  search_ready_2,
    output logic [31:0]           search_val_2,

    output logic                  clear,
    output logic [31:0]           clear_pc
);

    localparam logic [ROB_W:0] FULL_COUNT = (ROB_W+1)'(ROB_SIZE);

    logic        busy_q       [ROB_SIZE];
    logic        ready_q      [ROB_SIZE];
    logic        mispredict_q [ROB_SIZE];
    rob_type_e   type_q       [ROB_SIZE];
    logic [4:0]  rd_q         [ROB_SIZE];
    logic [31:0] val_q        [ROB_SIZE];
    logic [31:0] target_q     [ROB_SIZE];

    rob_id_t        head_q, tail_q;
    logic [ROB_W:0] count_q;
    logic           clear_q;
    logic [31:0]    clear_pc_q;

    logic issue_fire, commit_fire, flush_fire, wb_hit;

    // Issue is a one-way valid with rob_full as back-pressure: an issue is taken on the
    // clock edge only when issue_valid is high, rob_full is low, clear is low and rdy_in is high.
    assign rob_full     = (count_q == FULL_COUNT);
    assign issue_rob_id = tail_q;
    assign issue_fire   = rdy_in && issue_valid && !rob_full && !clear_q;
    assign commit_fire  = rdy_in && !clear_q && busy_q[head_q] && ready_q[head_q];
    assign flush_fire   = commit_fire && (type_q[head_q] == ROB_BR) && mispredict_q[head_q];
    assign wb_hit       = rdy_in && !clear_q && wb_valid && busy_q[wb_rob_id];

    assign commit_ready  = commit_fire;
    assign commit_rob_id = head_q;
    assign commit_val    = val_q[head_q];
    assign commit_reg_id = (commit_fire && type_q[head_q] == ROB_REG) ? rd_q[head_q] : 5'd0;
    assign commit_store  = commit_fire && (type_q[head_q] == ROB_ST);

    assign clear    = clear_q;
    assign clear_pc = clear_pc_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]       <= 1'b0;
                ready_q[i]      <= 1'b0;
                mispredict_q[i] <= 1'b0;
                type_q[i]       <= ROB_REG;
                rd_q[i]         <= 5'd0;
                val_q[i]        <= 32'd0;
                target_q[i]     <= 32'd0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            clear_q    <= 1'b0;
            clear_pc_q <= 32'd0;
        end else begin
            clear_q <= flush_fire;
            if (flush_fire) begin
                clear_pc_q <= target_q[head_q];
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_q[i]       <= 1'b0;
                    ready_q[i]      <= 1'b0;
                    mispredict_q[i] <= 1'b0;
                end
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (wb_hit) begin
                    ready_q[wb_rob_id]      <= 1'b1;
                    val_q[wb_rob_id]        <= wb_val;
                    mispredict_q[wb_rob_id] <= wb_mispredict;
                    target_q[wb_rob_id]     <= wb_target;
                end
                // The retiring entry is released after the writeback update so it ends up idle.
                if (commit_fire) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= rob_next(head_q);
                end
                if (issue_fire) begin
                    busy_q[tail_q]       <= 1'b1;
                    ready_q[tail_q]      <= 1'b0;
                    mispredict_q[tail_q] <= 1'b0;
                    type_q[tail_q]       <= rob_type_e'(issue_type);
                    rd_q[tail_q]         <= issue_rd;
                    tail_q               <= rob_next(tail_q);
                end
                case ({issue_fire, commit_fire})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Operand lookup with same-cycle writeback forwarding; idle entries read as empty.
    function automatic logic [32:0] lookup(input rob_id_t id);
        logic [32:0] r;
        r = 33'd0;
        if (busy_q[id]) begin
            if (wb_valid && wb_rob_id == id)
                r = {1'b1, wb_val};
            else
                r = {ready_q[id], val_q[id]};
        end
        return r;
    endfunction

    assign {search_ready_1, search_val_1} = lookup(search_rob_id_1);
    assign {search_ready_2, search_val_2} = lookup(search_rob_id_2);

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: in-order commit, full handling, mispredict flush,
// search forwarding, store commit and rdy_in stall.
`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif

module tb_rob;

    localparam int W = `ROB_WIDTH;
    localparam logic [1:0] T_REG = 2'd0;
    localparam logic [1:0] T_BR  = 2'd1;
    localparam logic [1:0] T_ST  = 2'd2;

    logic          clk_in = 1'b0;
    logic          rst_in, rdy_in;
    logic          issue_valid;
    logic [1:0]    issue_type;
    logic [4:0]    issue_rd;
    logic [W-1:0]  issue_rob_id;
    logic          rob_full;
    logic          wb_valid;
    logic [W-1:0]  wb_rob_id;
    logic [31:0]   wb_val;
    logic          wb_mispredict;
    logic [31:0]   wb_target;
    logic          commit_ready;
    logic [4:0]    commit_reg_id;
    logic [31:0]   commit_val;
    logic [W-1:0]  commit_rob_id;
    logic          commit_store;
    logic [W-1:0]  search_rob_id_1, search_rob_id_2;
    logic          search_ready_1, search_ready_2;
    logic [31:0]   search_val_1, search_val_2;
    logic          clear;
    logic [31:0]   clear_pc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    rob dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_rob_id(issue_rob_id), .rob_full(rob_full),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_val(wb_val),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .commit_ready(commit_ready), .commit_reg_id(commit_reg_id), .commit_val(commit_val),
        .commit_rob_id(commit_rob_id), .commit_store(commit_store),
        .search_rob_id_1(search_rob_id_1), .search_ready_1(search_ready_1), .search_val_1(search_val_1),
        .search_rob_id_2(search_rob_id_2), .search_ready_2(search_ready_2), .search_val_2(search_val_2),
        .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_type = T_REG; issue_rd = 5'd0;
        wb_valid = 1'b0; wb_rob_id = '0; wb_val = 32'd0; wb_mispredict = 1'b0; wb_target = 32'd0;
        search_rob_id_1 = '0; search_rob_id_2 = '0;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic [W-1:0] exp_id);
        check("issue_id", 32'(issue_rob_id), 32'(exp_id));
        issue_valid = 1'b1; issue_type = t; issue_rd = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [W-1:0] id, input logic [31:0] v, input logic mp, input logic [31:0] tgt);
        wb_valid = 1'b1; wb_rob_id = id; wb_val = v; wb_mispredict = mp; wb_target = tgt;
        tick();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_issue_id", 32'(issue_rob_id), 32'd0);
        check("rst_commit_ready", 32'(commit_ready), 32'd0);
        check("rst_commit_reg", 32'(commit_reg_id), 32'd0);
        check("rst_commit_store", 32'(commit_store), 32'd0);
        check("rst_clear", 32'(clear), 32'd0);
        check("rst_clear_pc", clear_pc, 32'd0);

        // Out-of-order writeback, in-order commit
        do_issue(T_REG, 5'd5, 0);
        do_issue(T_REG, 5'd5, 1);
        do_issue(T_REG, 5'd5, 2);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h11);
        do_wb(1, 32'h11, 1'b0, 32'd0);
        check("young_ready_no_commit", 32'(commit_ready), 32'd0);
        wb_valid = 1'b1; wb_rob_id = 0; wb_val = 32'h22; wb_mispredict = 1'b0;
        #1;
        check("wb_head_same_cycle", 32'(commit_ready), 32'd0);
        tick();
        wb_valid = 1'b0;
        check("c0_ready", 32'(commit_ready), 32'd1);
        check("c0_reg", 32'(commit_reg_id), 32'd5);
        check("c0_val", commit_val, exp_q.pop_front());
        check("c0_id", 32'(commit_rob_id), 32'd0);
        tick();
        check("c1_ready", 32'(commit_ready), 32'd1);
        check("c1_val", commit_val, exp_q.pop_front());
        check("c1_id", 32'(commit_rob_id), 32'd1);
        tick();
        check("c2_not_ready", 32'(commit_ready), 32'd0);
        check("c2_idle_reg", 32'(commit_reg_id), 32'd0);

        // Fill to capacity, reject when full even with a same-cycle commit
        do_reset();
        for (int i = 0; i < (1 << W); i++)
            do_issue(T_REG, 5'(i + 1), W'(i));
        check("full_set", 32'(rob_full), 32'd1);
        do_issue(T_REG, 5'd9, 0);
        check("ninth_ignored_full", 32'(rob_full), 32'd1);
        check("ninth_ignored_tail", 32'(issue_rob_id), 32'd0);
        do_wb(0, 32'h44, 1'b0, 32'd0);
        check("full_commit_ready", 32'(commit_ready), 32'd1);
        issue_valid = 1'b1; issue_type = T_REG; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        check("full_commit_issue_rejected", 32'(rob_full), 32'd0);
        check("full_commit_tail_held", 32'(issue_rob_id), 32'd0);
        do_issue(T_REG, 5'd9, 0);
        check("refill_full", 32'(rob_full), 32'd1);
        check("refill_tail", 32'(issue_rob_id), 32'd1);

        // Mispredicted branch with three younger ready entries
        do_reset();
        do_issue(T_BR, 5'd0, 0);
        do_issue(T_REG, 5'd3, 1);
        do_issue(T_REG, 5'd4, 2);
        do_issue(T_REG, 5'd6, 3);
        do_wb(1, 32'h1, 1'b0, 32'd0);
        do_wb(2, 32'h2, 1'b0, 32'd0);
        do_wb(3, 32'h3, 1'b0, 32'd0);
        do_wb(0, 32'hDEAD, 1'b1, 32'h100);
        check("br_commit", 32'(commit_ready), 32'd1);
        check("br_reg_zero", 32'(commit_reg_id), 32'd0);
        check("br_not_store", 32'(commit_store), 32'd0);
        tick();
        check("flush_clear", 32'(clear), 32'd1);
        check("flush_pc", clear_pc, 32'h100);
        check("flush_no_commit", 32'(commit_ready), 32'd0);
        check("flush_tail", 32'(issue_rob_id), 32'd0);
        check("flush_not_full", 32'(rob_full), 32'd0);
        issue_valid = 1'b1; issue_type = T_REG; issue_rd = 5'd2;
        tick();
        issue_valid = 1'b0;
        check("clear_one_cycle", 32'(clear), 32'd0);
        check("issue_during_clear_ignored", 32'(issue_rob_id), 32'd0);
        check("no_young_commit", 32'(commit_ready), 32'd0);
        search_rob_id_1 = 1;
        #1;
        check("flushed_entry_search", 32'(search_ready_1), 32'd0);

        // Search with writeback bypass
        do_issue(T_REG, 5'd8, 0);
        do_issue(T_REG, 5'd8, 1);
        do_issue(T_REG, 5'd8, 2);
        search_rob_id_1 = 2;
        wb_valid = 1'b1; wb_rob_id = 2; wb_val = 32'hABCD; wb_mispredict = 1'b0;
        #1;
        check("bypass_ready", 32'(search_ready_1), 32'd1);
        check("bypass_val", search_val_1, 32'hABCD);
        tick();
        wb_valid = 1'b0;
        search_rob_id_2 = 2;
        #1;
        check("stored_ready", 32'(search_ready_2), 32'd1);
        check("stored_val", search_val_2, 32'hABCD);
        search_rob_id_2 = 5;
        #1;
        check("idle_search_ready", 32'(search_ready_2), 32'd0);
        check("idle_search_val", search_val_2, 32'd0);
        search_rob_id_1 = 1;
        #1;
        check("busy_unready_search", 32'(search_ready_1), 32'd0);

        // Store commit and rdy_in stall
        do_reset();
        do_issue(T_ST, 5'd7, 0);
        do_wb(0, 32'h55, 1'b0, 32'd0);
        rdy_in = 1'b0;
        issue_valid = 1'b1; issue_type = T_REG; issue_rd = 5'd1;
        #1;
        check("stall_no_commit", 32'(commit_ready), 32'd0);
        check("stall_no_store", 32'(commit_store), 32'd0);
        tick();
        tick();
        issue_valid = 1'b0;
        check("stall_still_idle", 32'(commit_ready), 32'd0);
        check("stall_tail_held", 32'(issue_rob_id), 32'd1);
        rdy_in = 1'b1;
        #1;
        check("st_commit", 32'(commit_ready), 32'd1);
        check("st_store", 32'(commit_store), 32'd1);
        check("st_reg_zero", 32'(commit_reg_id), 32'd0);
        check("st_val", commit_val, 32'h55);
        tick();
        check("st_done", 32'(commit_ready), 32'd0);
        check("st_done_store", 32'(commit_store), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
